// File: rtl/mult_accum_if.sv
// Producer/consumer bundle around the frame accumulator: issue tags and product in, frame result and status out.
interface mult_accum_if #(
  parameter int ACC_W = 24
);
  logic                    in_valid;
  logic                    in_last;
  logic signed [15:0]      product;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_sum;
  logic [7:0]              out_count;
  logic                    out_sat;
  logic                    overrun;

  modport master (
    output in_valid, in_last, product, out_ready,
    input  out_valid, out_sum, out_count, out_sat, overrun
  );

  modport slave (
    input  in_valid, in_last, product, out_ready,
    output out_valid, out_sum, out_count, out_sat, overrun
  );
endinterface

// File: rtl/mult_accum.sv
// Saturating per-frame sum of multiplier products; result valid LATENCY+1 cycles after the last issue.
// Input is never stalled: a frame completing while the output is held is dropped and flagged on overrun.
module mult_accum #(
  parameter int LATENCY = 8,
  parameter int ACC_W   = 24
) (
  input logic         clk,
  input logic         rst,
  mult_accum_if.slave bus
);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [LATENCY-1:0]      r_tag_vld;
  logic [LATENCY-1:0]      r_tag_last;
  logic                    w_exit_vld;
  logic                    w_exit_last;

  logic signed [ACC_W-1:0] r_acc;
  logic [7:0]              r_cnt;
  logic                    r_satf;
  logic                    r_first;

  logic signed [ACC_W:0]   w_base;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_clip;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic [7:0]              w_cnt_nxt;
  logic                    w_sat_nxt;

  logic                    w_load;
  logic                    w_accept;
  logic                    r_out_vld;
  logic signed [ACC_W-1:0] r_out_sum;
  logic [7:0]              r_out_cnt;
  logic                    r_out_sat;
  logic                    r_overrun;

  // Tag delay line: the tag leaves stage LATENCY-1 in the same cycle its product arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld  <= '0;
      r_tag_last <= '0;
    end else begin
      r_tag_vld  <= (r_tag_vld << 1) | LATENCY'(bus.in_valid);
      r_tag_last <= (r_tag_last << 1) | LATENCY'(bus.in_valid & bus.in_last);
    end
  end

  assign w_exit_vld  = r_tag_vld[LATENCY-1];
  assign w_exit_last = r_tag_last[LATENCY-1];

  always_comb begin
    w_base    = r_first ? '0 : {r_acc[ACC_W-1], r_acc};
    w_sum     = w_base + {{(ACC_W-15){bus.product[15]}}, bus.product};
    w_clip    = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    w_acc_nxt = w_sum[ACC_W-1:0];
    if (w_clip) begin
      w_acc_nxt = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    w_cnt_nxt = r_first ? 8'd1 : ((r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1);
    w_sat_nxt = (r_first ? 1'b0 : r_satf) | w_clip;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_satf  <= 1'b0;
      r_first <= 1'b1;
    end else if (w_exit_vld) begin
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_satf  <= w_sat_nxt;
      r_first <= w_exit_last;
    end
  end

  assign w_load   = w_exit_vld & w_exit_last;
  assign w_accept = r_out_vld & bus.out_ready;

  // A held result wins over a newly completed frame; the new one is lost and reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_out_sum <= '0;
      r_out_cnt <= '0;
      r_out_sat <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load && (!r_out_vld || bus.out_ready)) begin
        r_out_vld <= 1'b1;
        r_out_sum <= w_acc_nxt;
        r_out_cnt <= w_cnt_nxt;
        r_out_sat <= w_sat_nxt;
      end else if (w_accept) begin
        r_out_vld <= 1'b0;
      end
      if (w_load && r_out_vld && !bus.out_ready) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign bus.out_valid = r_out_vld;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_count = r_out_cnt;
  assign bus.out_sat   = r_out_sat;
  assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_mult_accum.sv
// Bench for mult_accum: pipelined-multiplier stand-in, frame-level reference model, directed and random scenarios.
module tb_mult_accum;
  localparam int LAT   = 8;
  localparam int ACC_W = 24;
  localparam longint MAXV = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint MINV = -(longint'(1) << (ACC_W-1));

  typedef struct {
    longint sum;
    int     cnt;
    bit     sat;
    int     cyc;
  } res_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   vld_cnt;

  logic signed [15:0] mq[$];
  res_t cap_q[$];
  res_t exp_q[$];
  res_t mon_r;

  longint m_sum;
  int     m_cnt;
  bit     m_sat;
  bit     m_first;

  mult_accum_if #(.ACC_W(ACC_W)) bus ();

  mult_accum #(.LATENCY(LAT), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.out_valid) vld_cnt++;
    if (!rst && bus.out_valid && bus.out_ready) begin
      mon_r.sum = longint'(bus.out_sum);
      mon_r.cnt = int'(bus.out_count);
      mon_r.sat = bus.out_sat;
      mon_r.cyc = cyc;
      cap_q.push_back(mon_r);
    end
  end

  // Drives one cycle of issue; the product queue plays the multiplier, the model sums whole frames.
  task automatic set_in(bit v, bit l, int p);
    logic signed [15:0] pv;
    pv = v ? 16'(p) : 16'($urandom);
    bus.in_valid = v;
    bus.in_last  = l;
    mq.push_back(pv);
    if (mq.size() > LAT) bus.product = mq.pop_front();
    if (rst) begin
      m_first = 1;
    end else if (v) begin
      if (m_first) begin m_sum = 0; m_cnt = 0; m_sat = 0; end
      m_sum = m_sum + longint'(p);
      if (m_sum > MAXV) begin m_sum = MAXV; m_sat = 1; end
      else if (m_sum < MINV) begin m_sum = MINV; m_sat = 1; end
      if (m_cnt < 255) m_cnt++;
      m_first = l;
      if (l) exp_q.push_back('{sum: m_sum, cnt: m_cnt, sat: m_sat, cyc: cyc + LAT + 1});
    end
  endtask

  task automatic tick(bit v, bit l, int p);
    set_in(v, l, p);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_caps(int n, int budget);
    for (int i = 0; i < budget && cap_q.size() < n; i++) tick(0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    tick(0, 0, 0);
    tick(0, 0, 0);
    rst = 0;
    exp_q.delete();
    cap_q.delete();
    vld_cnt = 0;
  endtask

  task automatic test_reset();
    tick(0, 0, 0);
    tick(0, 0, 0);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0d want 0", bus.out_valid); end
    n_tests++; if (longint'(bus.out_sum) !== 0) begin n_fail++; $display("FAIL rst_sum: got %0d want 0", bus.out_sum); end
    n_tests++; if (bus.out_count !== 8'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", bus.out_count); end
    n_tests++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL rst_sat: got %0d want 0", bus.out_sat); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %0d want 0", bus.overrun); end
    rst = 0;
    bus.out_ready = 0;
    tick(1, 0, 3);
    tick(1, 1, 4);
    repeat (LAT + 2) tick(0, 0, 0);
    tick(1, 1, 9);
    repeat (LAT + 2) tick(0, 0, 0);
    tick(1, 0, 11);
    tick(1, 0, 12);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_valid: got %0d want 1", bus.out_valid); end
    n_tests++; if (longint'(bus.out_sum) !== 7) begin n_fail++; $display("FAIL pre_rst_sum: got %0d want 7", bus.out_sum); end
    n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL pre_rst_overrun: got %0d want 1", bus.overrun); end
    set_in(1, 1, 13);
    #3;
    rst = 1;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %0d want 0", bus.out_valid); end
    n_tests++; if (longint'(bus.out_sum) !== 0) begin n_fail++; $display("FAIL async_rst_sum: got %0d want 0", bus.out_sum); end
    n_tests++; if (bus.out_count !== 8'd0) begin n_fail++; $display("FAIL async_rst_count: got %0d want 0", bus.out_count); end
    n_tests++; if (bus.out_sat !== 1'b0) begin n_fail++; $display("FAIL async_rst_sat: got %0d want 0", bus.out_sat); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL async_rst_overrun: got %0d want 0", bus.overrun); end
    @(posedge clk);
    #1;
    tick(1, 1, 5);
    rst = 0;
    vld_cnt = 0;
    bus.out_ready = 1;
    repeat (LAT + 4) tick(0, 0, 0);
    n_tests++; if (vld_cnt !== 0) begin n_fail++; $display("FAIL post_rst_no_valid: got %0d valid cycles want 0", vld_cnt); end
  endtask

  task automatic test_basic();
    int last_cyc;
    do_reset();
    bus.out_ready = 1;
    tick(1, 0, 15);
    tick(1, 0, -20);
    tick(1, 0, 100);
    last_cyc = cyc;
    tick(1, 1, 0);
    wait_caps(1, 30);
    n_tests++; if (cap_q.size() !== 1) begin n_fail++; $display("FAIL basic_results: got %0d want 1", cap_q.size()); end
    if (cap_q.size() > 0) begin
      n_tests++; if (cap_q[0].sum !== 95) begin n_fail++; $display("FAIL basic_sum: got %0d want 95", cap_q[0].sum); end
      n_tests++; if (cap_q[0].cnt !== 4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", cap_q[0].cnt); end
      n_tests++; if (cap_q[0].sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %0d want 0", cap_q[0].sat); end
      n_tests++; if (cap_q[0].cyc !== last_cyc + LAT + 1) begin n_fail++; $display("FAIL basic_latency: got cycle %0d want %0d", cap_q[0].cyc, last_cyc + LAT + 1); end
    end
    n_tests++; if (vld_cnt !== 1) begin n_fail++; $display("FAIL basic_valid_cycles: got %0d want 1", vld_cnt); end
  endtask

  task automatic test_back_to_back();
    int bs[3] = '{-32640, 32385, 1};
    int c0;
    do_reset();
    bus.out_ready = 1;
    c0 = cyc;
    for (int i = 0; i < 3; i++) tick(1, 1, bs[i]);
    wait_caps(3, 30);
    n_tests++; if (cap_q.size() !== 3) begin n_fail++; $display("FAIL b2b_results: got %0d want 3", cap_q.size()); end
    for (int i = 0; i < 3 && i < cap_q.size(); i++) begin
      n_tests++; if (cap_q[i].sum !== longint'(bs[i])) begin n_fail++; $display("FAIL b2b_sum[%0d]: got %0d want %0d", i, cap_q[i].sum, bs[i]); end
      n_tests++; if (cap_q[i].cnt !== 1) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 1", i, cap_q[i].cnt); end
      n_tests++; if (cap_q[i].cyc !== c0 + i + LAT + 1) begin n_fail++; $display("FAIL b2b_cycle[%0d]: got %0d want %0d", i, cap_q[i].cyc, c0 + i + LAT + 1); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    bus.out_ready = 1;
    for (int i = 0; i < 300; i++) tick(1, i == 299, 32385);
    wait_caps(1, 30);
    n_tests++; if (cap_q.size() !== 1) begin n_fail++; $display("FAIL sat_results: got %0d want 1", cap_q.size()); end
    if (cap_q.size() > 0) begin
      n_tests++; if (cap_q[0].sum !== 8388607) begin n_fail++; $display("FAIL sat_sum: got %0d want 8388607", cap_q[0].sum); end
      n_tests++; if (cap_q[0].sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag: got %0d want 1", cap_q[0].sat); end
      n_tests++; if (cap_q[0].cnt !== 255) begin n_fail++; $display("FAIL sat_count: got %0d want 255", cap_q[0].cnt); end
    end
    tick(1, 1, 5);
    wait_caps(2, 30);
    n_tests++; if (cap_q.size() !== 2) begin n_fail++; $display("FAIL sat_next_results: got %0d want 2", cap_q.size()); end
    if (cap_q.size() > 1) begin
      n_tests++; if (cap_q[1].sum !== 5) begin n_fail++; $display("FAIL sat_next_sum: got %0d want 5", cap_q[1].sum); end
      n_tests++; if (cap_q[1].sat !== 1'b0) begin n_fail++; $display("FAIL sat_next_flag: got %0d want 0", cap_q[1].sat); end
      n_tests++; if (cap_q[1].cnt !== 1) begin n_fail++; $display("FAIL sat_next_count: got %0d want 1", cap_q[1].cnt); end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    bus.out_ready = 0;
    tick(1, 0, 4);
    tick(1, 1, 6);
    repeat (LAT + 2) tick(0, 0, 0);
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_a_valid: got %0d want 1", bus.out_valid); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_a_overrun: got %0d want 0", bus.overrun); end
    tick(1, 1, 7);
    repeat (LAT + 2) tick(0, 0, 0);
    n_tests++; if (longint'(bus.out_sum) !== 10) begin n_fail++; $display("FAIL ovr_held_sum: got %0d want 10", bus.out_sum); end
    n_tests++; if (bus.out_count !== 8'd2) begin n_fail++; $display("FAIL ovr_held_count: got %0d want 2", bus.out_count); end
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_held_valid: got %0d want 1", bus.out_valid); end
    n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %0d want 1", bus.overrun); end
    bus.out_ready = 1;
    tick(0, 0, 0);
    n_tests++; if (cap_q.size() !== 1) begin n_fail++; $display("FAIL ovr_accepts: got %0d want 1", cap_q.size()); end
    if (cap_q.size() > 0) begin
      n_tests++; if (cap_q[0].sum !== 10) begin n_fail++; $display("FAIL ovr_accept_sum: got %0d want 10", cap_q[0].sum); end
    end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_after_valid: got %0d want 0", bus.out_valid); end
    n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %0d want 1", bus.overrun); end
  endtask

  task automatic test_simul_accept_load();
    int a;
    do_reset();
    bus.out_ready = 0;
    a = cyc;
    tick(1, 1, 10);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(1, 1, 20);
    for (int i = 0; i < 20 && cyc < a + LAT + 3; i++) tick(0, 0, 0);
    bus.out_ready = 1;
    tick(0, 0, 0);
    bus.out_ready = 0;
    n_tests++; if (cap_q.size() !== 1) begin n_fail++; $display("FAIL simul_accepts: got %0d want 1", cap_q.size()); end
    if (cap_q.size() > 0) begin
      n_tests++; if (cap_q[0].sum !== 10) begin n_fail++; $display("FAIL simul_a_sum: got %0d want 10", cap_q[0].sum); end
      n_tests++; if (cap_q[0].cyc !== a + LAT + 3) begin n_fail++; $display("FAIL simul_a_cycle: got %0d want %0d", cap_q[0].cyc, a + LAT + 3); end
    end
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL simul_b_valid: got %0d want 1", bus.out_valid); end
    n_tests++; if (longint'(bus.out_sum) !== 20) begin n_fail++; $display("FAIL simul_b_sum: got %0d want 20", bus.out_sum); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL simul_overrun: got %0d want 0", bus.overrun); end
  endtask

  task automatic test_random();
    bit v;
    bit l;
    int p;
    do_reset();
    bus.out_ready = 1;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 5) == 0);
      p = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? -32640 : 32385)
                                      : int'($urandom_range(0, 65025)) - 32640;
      tick(v, l, p);
    end
    wait_caps(exp_q.size(), 40);
    n_tests++; if (cap_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_results: got %0d want %0d", cap_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_tests++;
      if (cap_q[i].sum !== exp_q[i].sum || cap_q[i].cnt !== exp_q[i].cnt ||
          cap_q[i].sat !== exp_q[i].sat || cap_q[i].cyc !== exp_q[i].cyc) begin
        n_fail++;
        $display("FAIL rand_frame[%0d]: got sum %0d cnt %0d sat %0d cyc %0d want sum %0d cnt %0d sat %0d cyc %0d",
                 i, cap_q[i].sum, cap_q[i].cnt, cap_q[i].sat, cap_q[i].cyc,
                 exp_q[i].sum, exp_q[i].cnt, exp_q[i].sat, exp_q[i].cyc);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clk = 0;
    cyc = 0;
    rst = 1;
    n_tests = 0;
    n_fail = 0;
    vld_cnt = 0;
    m_first = 1;
    m_sum = 0;
    m_cnt = 0;
    m_sat = 0;
    bus.in_valid = 0;
    bus.in_last = 0;
    bus.product = '0;
    bus.out_ready = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturation();
    test_overrun();
    test_simul_accept_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_accum.md
# mult_accum

Signed product accumulator sitting directly downstream of the team's 8-bit unsigned × signed pipelined multiplier. It tracks operand-issue tags through a delay line matched to the multiplier latency, sums the 16-bit two's-complement products of each frame with saturation, and presents one frame sum per frame on a ready/valid output. The multiplier cannot stall, so this block never back-pressures its input; it reports lost results instead.

## Interface
- LATENCY, 8, cycles from operands presented to the multiplier until the matching product appears on `product`
- ACC_W, 24, accumulator and output sum width (signed), ≥17

- clk  in  1  rising-edge clock, shared with the multiplier
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands are presented to the multiplier this cycle
- in_last  in  1  qualifies in_valid: this operand pair is the last of a frame
- product  in  16  signed two's-complement product from the multiplier
- out_valid  out  1  out_sum, out_count and out_sat hold a completed frame
- out_ready  in  1  consumer accepts the result when high with out_valid
- out_sum  out  ACC_W  signed saturated frame sum
- out_count  out  8  products in the frame, saturating at 255
- out_sat  out  1  out_sum was clipped at some point in the frame
- overrun  out  1  sticky: a completed frame was dropped because out_valid was held

## Operation
- Tag pipe: LATENCY-stage shift register of {valid, last} = {in_valid, in_valid & in_last}. The tag exits aligned with its product. in_last without in_valid is ignored.
- Frame state: first_flag is set at reset and after every accepted last tag.
- On an exiting valid tag, the block updates:
  - acc ← sat((first_flag ? 0 : acc) + sext(product))
  - cnt ← first_flag ? 1 : min(cnt+1, 255)
  - satf ← (first_flag ? 0 : satf) | clipped
  - Clear first_flag.
- Saturation range is −2^(ACC_W−1) … 2^(ACC_W−1)−1. The addition is done at ACC_W+1 bits, then clipped.
- On an exiting valid+last tag, the result register loads the post-update {acc, cnt, satf} and sets out_valid. The next frame starts with first_flag set.
- Output handshake: the result is held stable while out_valid && !out_ready. The transfer occurs on a cycle with out_valid && out_ready. out_valid then clears unless a new result loads the same cycle.
- Simultaneous accept and new last: the new result loads and out_valid stays 1. No overrun.
- New last while out_valid && !out_ready: the new result is dropped, the held result is unchanged, and overrun is set to 1 until reset. Accumulator state still restarts for the next frame.
- Frames may be back-to-back with no idle cycles. Gaps inside a frame are allowed; acc holds between products.

## Timing
- Reset (async assert, sync deassert by system):
  - tag pipe, acc, cnt and satf clear to 0; first_flag is set to 1.
  - out_valid=0, out_sum=0, out_count=0, out_sat=0, overrun=0.
  - Products in flight in the multiplier at reset are discarded because their tags are cleared.
- Reset mid-frame: partial sum is lost. The first valid tag after reset starts a new frame.
- Latency: in_valid&in_last in cycle t → out_valid=1 from cycle t+LATENCY+1.
- Throughput: one product per cycle, one frame result per cycle (single-product frames back-to-back) when out_ready is held high.
- All outputs are registered. No combinational path from out_ready or product to any output.

## Test plan
- Reset values: assert rst mid-stream → all outputs 0 immediately, without waiting for a clock edge. Release rst → no out_valid for tags issued before reset.
- Basic frame: products 15, −20, 100, 0 with last on the 4th product → out_sum=95, out_count=4, out_sat=0, out_valid rising exactly LATENCY+1 cycles after the last issue.
- Single-product back-to-back frames, out_ready=1: products −32640, 32385, 1, each with last → three consecutive out_valid cycles with sums −32640, 32385, 1 and count 1 each.
- Saturation and count cap: 300-product frame of 32385 (255×127) → out_sum=8388607, out_sat=1, out_count=255. The next frame of one product 5 → sum 5, sat 0.
- Back-pressure and overrun:
  - Frame A sum 10 completes with out_ready=0, then frame B (sum 7) completes → out_sum stays 10 and overrun=1.
  - Raise out_ready → A is accepted, out_valid=0, overrun stays 1.
- Simultaneous accept and load: frame A is pending, out_ready=1 in the same cycle frame B's last exits → A transfers, B loads, out_valid stays 1, overrun=0.
